// File: rtl/audio_output_sampler.sv
// Purpose: resample the stereo mix onto a fractional-rate strobe and apply a soft-mute gain ramp (AUDIO_OUT_SOFT_MUTE_EN; hard mute otherwise).
// Latency: strobe cycle N captures the inputs, N+1 multiplies, and outputs plus sample_valid appear in N+2.
// Backpressure: none; the output is a free-running sample stream and holds between sample_valid pulses.
module audio_output_sampler #(
    parameter int CLK_HZ    = 30000000,
    parameter int SAMPLE_HZ = 44100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] audio_left_in,
    input  logic [15:0] audio_right_in,
    input  logic        mute,
    output logic        sample_valid,
    output logic [15:0] audio_left_out,
    output logic [15:0] audio_right_out,
    output logic        muted
);

    localparam logic [31:0] ACC_INC = 32'(SAMPLE_HZ);
    localparam logic [31:0] ACC_MOD = 32'(CLK_HZ);

    localparam logic [1:0] ST_MUTED     = 2'd0;
    localparam logic [1:0] ST_UNMUTED   = 2'd2;
`ifdef AUDIO_OUT_SOFT_MUTE_EN
    localparam logic [1:0] ST_RAMP_UP   = 2'd1;
    localparam logic [1:0] ST_RAMP_DOWN = 2'd3;
`endif

    logic [31:0]        acc;
    logic [31:0]        acc_sum;
    logic               strobe;
    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [8:0]         gain;
    logic [8:0]         gain_nxt;
    logic [8:0]         prod_gain;
    logic signed [15:0] in_l;
    logic signed [15:0] in_r;
    logic               stage_vld;
    logic signed [25:0] prod_l;
    logic signed [25:0] prod_r;

    // acc < CLK_HZ < 2^31 and SAMPLE_HZ <= CLK_HZ/4, so the sum never wraps 32 bits.
    assign acc_sum = acc + ACC_INC;
    assign strobe  = (acc_sum >= ACC_MOD);

    always_comb begin
        state_nxt = state;
        gain_nxt  = gain;
`ifdef AUDIO_OUT_SOFT_MUTE_EN
        // A reversal that lands on an end point settles directly into the terminal state.
        case (state)
            ST_MUTED: begin
                if (!mute) begin
                    state_nxt = ST_RAMP_UP;
                    gain_nxt  = 9'd1;
                end
            end
            ST_RAMP_UP: begin
                if (mute) begin
                    gain_nxt  = gain - 9'd1;
                    state_nxt = (gain == 9'd1) ? ST_MUTED : ST_RAMP_DOWN;
                end else begin
                    gain_nxt  = gain + 9'd1;
                    state_nxt = (gain == 9'd255) ? ST_UNMUTED : ST_RAMP_UP;
                end
            end
            ST_UNMUTED: begin
                if (mute) begin
                    state_nxt = ST_RAMP_DOWN;
                    gain_nxt  = 9'd255;
                end
            end
            ST_RAMP_DOWN: begin
                if (!mute) begin
                    gain_nxt  = gain + 9'd1;
                    state_nxt = (gain == 9'd255) ? ST_UNMUTED : ST_RAMP_UP;
                end else begin
                    gain_nxt  = gain - 9'd1;
                    state_nxt = (gain == 9'd1) ? ST_MUTED : ST_RAMP_DOWN;
                end
            end
            default: begin
                state_nxt = ST_MUTED;
                gain_nxt  = 9'd0;
            end
        endcase
`else
        if (mute) begin
            state_nxt = ST_MUTED;
            gain_nxt  = 9'd0;
        end else begin
            state_nxt = ST_UNMUTED;
            gain_nxt  = 9'd256;
        end
`endif
    end

    // Zero-extended gain keeps 256 positive, so unity passes -32768 through exactly.
    assign prod_l = $signed({1'b0, prod_gain}) * in_l;
    assign prod_r = $signed({1'b0, prod_gain}) * in_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc             <= '0;
            state           <= ST_MUTED;
            gain            <= '0;
            prod_gain       <= '0;
            in_l            <= '0;
            in_r            <= '0;
            stage_vld       <= 1'b0;
            sample_valid    <= 1'b0;
            audio_left_out  <= '0;
            audio_right_out <= '0;
        end else begin
            acc          <= strobe ? (acc_sum - ACC_MOD) : acc_sum;
            stage_vld    <= strobe;
            sample_valid <= stage_vld;
            if (strobe) begin
                in_l      <= audio_left_in;
                in_r      <= audio_right_in;
                prod_gain <= gain;
                gain      <= gain_nxt;
                state     <= state_nxt;
            end
            if (stage_vld) begin
                audio_left_out  <= 16'(prod_l >>> 8);
                audio_right_out <= 16'(prod_r >>> 8);
            end
        end
    end

    assign muted = (state == ST_MUTED);

endmodule

// File: tb/tb_audio_output_sampler.sv
// Randomized and directed bench for audio_output_sampler with a gain/queue reference model.
module tb_audio_output_sampler;

    localparam int C = 1003;
    localparam int S = 211;
`ifdef AUDIO_OUT_SOFT_MUTE_EN
    localparam bit SOFT = 1'b1;
`else
    localparam bit SOFT = 1'b0;
`endif
    localparam int SECOND_L  = SOFT ? 64 : 16384;
    localparam int TOGGLE2_L = SOFT ? 18 : 4660;
    localparam int ROUND_R   = SOFT ? 1 : 3;
    localparam int MAX_SLEW  = SOFT ? 64 : 16384;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mute = 1'b1;
    logic [15:0] audio_left_in = '0;
    logic [15:0] audio_right_in = '0;
    logic        sample_valid;
    logic [15:0] audio_left_out;
    logic [15:0] audio_right_out;
    logic        muted;

    audio_output_sampler #(.CLK_HZ(C), .SAMPLE_HZ(S)) dut (
        .clk             (clk),
        .reset           (reset),
        .audio_left_in   (audio_left_in),
        .audio_right_in  (audio_right_in),
        .mute            (mute),
        .sample_valid    (sample_valid),
        .audio_left_out  (audio_left_out),
        .audio_right_out (audio_right_out),
        .muted           (muted)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int l;
        int r;
    } exp_t;

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   m_acc = 0;
    int   m_gain = 0;
    int   m_strobes = 0;
    int   e_l = 0;
    int   e_r = 0;
    bit   e_vld = 1'b0;
    exp_t pend[$];

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs != exp_v) begin
            n_fail++;
            if (n_fail <= 50)
                $display("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic int scale(input int g, input int s);
        return (g * s) >>> 8;
    endfunction

    function automatic int next_gain(input int g, input bit m);
        if (SOFT)
            return m ? ((g > 0) ? g - 1 : 0) : ((g < 256) ? g + 1 : 256);
        return m ? 0 : 256;
    endfunction

    function automatic int sl();
        return int'($signed(audio_left_out));
    endfunction

    function automatic int sr();
        return int'($signed(audio_right_out));
    endfunction

    // One clock: model update at the rising edge, DUT comparison at the falling edge.
    task automatic run_cycle();
        int   l;
        int   r;
        exp_t e;
        @(posedge clk);
        cyc++;
        l = int'($signed(audio_left_in));
        r = int'($signed(audio_right_in));
        if (reset) begin
            m_acc  = 0;
            m_gain = 0;
            pend.delete();
            e_vld  = 1'b0;
            e_l    = 0;
            e_r    = 0;
        end else begin
            e_vld = 1'b0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                e     = pend.pop_front();
                e_vld = 1'b1;
                e_l   = e.l;
                e_r   = e.r;
            end
            if (m_acc + S >= C) begin
                e.due = cyc + 1;
                e.l   = scale(m_gain, l);
                e.r   = scale(m_gain, r);
                pend.push_back(e);
                m_gain = next_gain(m_gain, mute);
                m_acc  = m_acc + S - C;
                m_strobes++;
            end else begin
                m_acc = m_acc + S;
            end
        end
        @(negedge clk);
        chk("sample_valid", int'(sample_valid), int'(e_vld));
        chk("left_out", sl(), e_l);
        chk("right_out", sr(), e_r);
        chk("muted", int'(muted), (m_gain == 0) ? 1 : 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) run_cycle();
        reset = 1'b0;
    endtask

    task automatic wait_strobes(input int n);
        int target;
        target = m_strobes + n;
        for (int i = 0; i < 10 * n + 20 && m_strobes < target; i++) run_cycle();
        if (m_strobes < target) chk("strobe_timeout", m_strobes, target);
    endtask

    initial begin
        int n_out;
        int prev;
        int start;
        int cnt;
        int last;
        int diff;

        // Reset state
        do_reset();
        chk("reset_valid", int'(sample_valid), 0);
        chk("reset_left", sl(), 0);
        chk("reset_muted", int'(muted), 1);

        // Ramp up from silence
        mute = 1'b0;
        audio_left_in  = 16'h4000;
        audio_right_in = 16'hC000;
        n_out = 0;
        for (int i = 0; i < 3000 && n_out < 257; i++) begin
            run_cycle();
            if (sample_valid) begin
                n_out++;
                if (n_out == 1) chk("ramp_first_l", sl(), 0);
                if (n_out == 2) begin
                    chk("ramp_second_l", sl(), SECOND_L);
                    chk("ramp_second_r", sr(), -SECOND_L);
                end
                if (n_out == 257) begin
                    chk("ramp_full_l", sl(), 16384);
                    chk("ramp_full_r", sr(), -16384);
                end
            end
        end
        chk("ramp_outputs", n_out, 257);

        // Reversal mid-ramp: fade down 10 strobes, then back up; output slew bounded
        mute  = 1'b1;
        start = m_strobes;
        prev  = sl();
        for (int i = 0; i < 500; i++) begin
            if (m_strobes >= start + 10) mute = 1'b0;
            run_cycle();
            if (sample_valid) begin
                diff = sl() - prev;
                if (diff < 0) diff = -diff;
                chk("reversal_slew_ok", (diff <= MAX_SLEW) ? 1 : 0, 1);
                prev = sl();
            end
        end

        // Truncation toward minus infinity at half gain, exact unity for -32768
        do_reset();
        mute = 1'b0;
        wait_strobes(128);
        audio_left_in  = 16'hFFFF;
        audio_right_in = 16'h0003;
        wait_strobes(1);
        run_cycle();
        chk("round_valid", int'(sample_valid), 1);
        chk("round_left", sl(), -1);
        chk("round_right", sr(), ROUND_R);
        for (int i = 0; i < 2000 && m_gain < 256; i++) run_cycle();
        audio_left_in = 16'h8000;
        wait_strobes(1);
        run_cycle();
        chk("unity_min_valid", int'(sample_valid), 1);
        chk("unity_min_left", sl(), -32768);

        // Reset mid-ramp
        do_reset();
        mute = 1'b0;
        audio_left_in = 16'h2345;
        wait_strobes(100);
        reset = 1'b1;
        run_cycle();
        reset = 1'b0;
        chk("midreset_left", sl(), 0);
        chk("midreset_muted", int'(muted), 1);
        chk("midreset_valid", int'(sample_valid), 0);
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            run_cycle();
            cnt++;
            if (sample_valid) break;
        end
        chk("first_valid_delay", cnt, (C + S - 1) / S + 1);

        // Mute release: second sample after the toggle
        mute = 1'b1;
        do_reset();
        audio_left_in = 16'h1234;
        wait_strobes(2);
        run_cycle();
        run_cycle();
        mute  = 1'b0;
        n_out = 0;
        for (int i = 0; i < 40 && n_out < 2; i++) begin
            run_cycle();
            if (sample_valid) n_out++;
        end
        chk("toggle_second_count", n_out, 2);
        chk("toggle_second_left", sl(), TOGGLE2_L);

        // Strobe count and spacing over CLK_HZ cycles
        do_reset();
        cnt  = 0;
        last = -1;
        for (int i = 1; i <= C + 1; i++) begin
            run_cycle();
            if (sample_valid) begin
                cnt++;
                if (last >= 0)
                    chk("spacing_ok", ((i - last == C / S) || (i - last == C / S + 1)) ? 1 : 0, 1);
                last = i;
            end
        end
        chk("strobe_count", cnt, S);

        // Randomized traffic with mute toggles and occasional resets
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            audio_left_in  = 16'($urandom);
            audio_right_in = 16'($urandom);
            if ($urandom_range(0, 99) == 0) mute = ~mute;
            reset = ($urandom_range(0, 1999) == 0);
            run_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
